pet_needs_engine: RTL and testbench

Parametrised successor to the fixed tamagotchi state logic. Tracks NUM_NEEDS independent need levels (hunger, health, energy, fun, ...), each with its own decay timer and refill event. A pet-condition FSM and a figure selector sit on top of the levels. It takes debounced button and sensor pulses from the button and sensor front-ends, and drives the LCD figure-select bus and level readouts.

---
 rtl/pet_needs_engine.sv | 161 ++++++++++++++++
 tb/tb_pet_needs_engine.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pet_needs_engine.sv
// Need-level tracker: per-channel decay/refill, pet-condition FSM and LCD figure selector.
// Levels, state and figure update one edge after an input pulse; tick is decoded from the prescaler.
module pet_needs_engine #(
  parameter int NUM_NEEDS    = 4,
  parameter int MAX_LEVEL    = 5,
  parameter int LOW_THRESH   = 2,
  parameter int REFILL       = 2,
  parameter int DIVISOR      = 2500000,
  parameter int TEST_DIVISOR = 250000,
  parameter int DECAY_TICKS  = 10,
  parameter int DEATH_TICKS  = 20,
  localparam int LEVEL_W     = $clog2(MAX_LEVEL + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_NEEDS-1:0]         evt,
  input  logic                         btn_reset,
  input  logic                         btn_test,
  output logic [NUM_NEEDS*LEVEL_W-1:0] level_bus,
  output logic [1:0]                   pet_state,
  output logic [3:0]                   figure_sel,
  output logic                         tick,
  output logic                         test_active
);
  localparam int PMAX = (DIVISOR > TEST_DIVISOR) ? DIVISOR : TEST_DIVISOR;
  localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam int DW   = $clog2(DECAY_TICKS + 1);
  localparam int KW   = $clog2(DEATH_TICKS + 1);
  localparam int SW   = LEVEL_W + 1;

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_NEEDY = 2'd1,
    ST_CRIT  = 2'd2,
    ST_DEAD  = 2'd3
  } state_t;

  logic [PW-1:0]      presc_q, presc_d, presc_last;
  logic               test_q, test_d;
  logic [LEVEL_W-1:0] lvl_q  [NUM_NEEDS];
  logic [LEVEL_W-1:0] lvl_d  [NUM_NEEDS];
  logic [DW-1:0]      dcnt_q [NUM_NEEDS];
  logic [DW-1:0]      dcnt_d [NUM_NEEDS];
  logic [KW-1:0]      death_q, death_d;
  state_t             state_q, state_d;
  logic [3:0]         fig_q, fig_d;
  logic               dead, any_zero, all_zero, any_low, death_hit;
  logic [2:0]         low_idx;

  assign presc_last  = test_q ? PW'(TEST_DIVISOR - 1) : PW'(DIVISOR - 1);
  assign tick        = (presc_q == presc_last);
  assign pet_state   = state_q;
  assign figure_sel  = fig_q;
  assign test_active = test_q;

  for (genvar g = 0; g < NUM_NEEDS; g++) begin : g_bus
    assign level_bus[g*LEVEL_W +: LEVEL_W] = lvl_q[g];
  end

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    test_d  = test_q;
    if (btn_test) begin
      test_d  = ~test_q;
      presc_d = '0;
    end

    dead = (state_q == ST_DEAD);

    // Refill wins over a coinciding decay step; the decay counter restarts either way.
    for (int i = 0; i < NUM_NEEDS; i++) begin
      logic [SW-1:0] sum;
      logic [DW-1:0] dinc;
      sum       = {1'b0, lvl_q[i]} + SW'(REFILL);
      dinc      = dcnt_q[i] + DW'(1);
      lvl_d[i]  = lvl_q[i];
      dcnt_d[i] = dcnt_q[i];
      if (!dead) begin
        if (evt[i]) begin
          lvl_d[i]  = (sum > SW'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL) : sum[LEVEL_W-1:0];
          dcnt_d[i] = '0;
        end else if (tick) begin
          if (dinc == DW'(DECAY_TICKS)) begin
            dcnt_d[i] = '0;
            if (lvl_q[i] != '0) lvl_d[i] = lvl_q[i] - LEVEL_W'(1);
          end else begin
            dcnt_d[i] = dinc;
          end
        end
      end
    end

    any_zero = 1'b0;
    all_zero = 1'b1;
    any_low  = 1'b0;
    low_idx  = '0;
    // Descending scan so the lowest-numbered needy channel is the one kept.
    for (int i = NUM_NEEDS - 1; i >= 0; i--) begin
      if (lvl_d[i] == '0) any_zero = 1'b1;
      else                all_zero = 1'b0;
      if (lvl_d[i] <= LEVEL_W'(LOW_THRESH)) begin
        any_low = 1'b1;
        low_idx = 3'(i);
      end
    end

    death_d = '0;
    if (dead)                  death_d = death_q;
    else if (state_q == ST_CRIT) death_d = tick ? death_q + KW'(1) : death_q;
    death_hit = (state_q == ST_CRIT) && (death_d == KW'(DEATH_TICKS));

    if (dead || all_zero || death_hit) state_d = ST_DEAD;
    else if (any_zero)                 state_d = ST_CRIT;
    else if (any_low)                  state_d = ST_NEEDY;
    else                               state_d = ST_OK;

    case (state_d)
      ST_NEEDY: fig_d = {1'b0, low_idx} + 4'd1;
      ST_CRIT:  fig_d = 4'd8;
      ST_DEAD:  fig_d = 4'd15;
      default:  fig_d = 4'd0;
    endcase

    if (btn_reset) begin
      presc_d = '0;
      test_d  = 1'b0;
      death_d = '0;
      state_d = ST_OK;
      fig_d   = 4'd0;
      for (int i = 0; i < NUM_NEEDS; i++) begin
        lvl_d[i]  = LEVEL_W'(MAX_LEVEL);
        dcnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      test_q  <= 1'b0;
      death_q <= '0;
      state_q <= ST_OK;
      fig_q   <= 4'd0;
      for (int i = 0; i < NUM_NEEDS; i++) begin
        lvl_q[i]  <= LEVEL_W'(MAX_LEVEL);
        dcnt_q[i] <= '0;
      end
    end else begin
      presc_q <= presc_d;
      test_q  <= test_d;
      death_q <= death_d;
      state_q <= state_d;
      fig_q   <= fig_d;
      for (int i = 0; i < NUM_NEEDS; i++) begin
        lvl_q[i]  <= lvl_d[i];
        dcnt_q[i] <= dcnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pet_needs_engine.sv
// Directed bench for pet_needs_engine with small divisors; E counts edges since the last reset.
module tb_pet_needs_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  evt = 4'b0;
  logic        btn_reset = 1'b0;
  logic        btn_test = 1'b0;
  logic [11:0] level_bus;
  logic [1:0]  pet_state;
  logic [3:0]  figure_sel;
  logic        tick;
  logic        test_active;

  int vec  = 0;
  int miss = 0;

  pet_needs_engine #(
    .NUM_NEEDS(4), .MAX_LEVEL(5), .LOW_THRESH(2), .REFILL(2),
    .DIVISOR(4), .TEST_DIVISOR(2), .DECAY_TICKS(3), .DEATH_TICKS(2)
  ) dut (
    .clk(clk), .rst(rst), .evt(evt), .btn_reset(btn_reset), .btn_test(btn_test),
    .level_bus(level_bus), .pet_state(pet_state), .figure_sel(figure_sel),
    .tick(tick), .test_active(test_active)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] lv(input int a3, input int a2, input int a1, input int a0);
    return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  initial begin
    // Power-on reset values
    step(2);
    chk("por_levels", level_bus, lv(5,5,5,5));
    chk("por_state", pet_state, 0);
    chk("por_fig", figure_sel, 0);
    chk("por_test", test_active, 0);
    chk("por_tick", tick, 0);
    rst = 1'b1;
    step(3);
    btn_test = 1'b1; step(1); btn_test = 1'b0;
    chk("pre_test_on", test_active, 1);
    step(2);
    // Asynchronous reset mid-cycle
    #2 rst = 1'b0; #1;
    chk("arst_test", test_active, 0);
    chk("arst_levels", level_bus, lv(5,5,5,5));
    chk("arst_tick", tick, 0);
    @(posedge clk); #1 rst = 1'b1;

    // Idle decay
    for (int e = 1; e <= 4; e++) begin
      step(1);
      chk("tick_normal", tick, (e == 3) ? 1'b1 : 1'b0);
    end
    step(7);  chk("decay_e11", level_bus, lv(5,5,5,5));
    step(1);  chk("decay_e12", level_bus, lv(4,4,4,4));
    step(12); chk("decay_e24", level_bus, lv(3,3,3,3));
    chk("decay_e24_state", pet_state, 0);
    step(12); chk("decay_e36", level_bus, lv(2,2,2,2));
    chk("decay_e36_state", pet_state, 1);
    chk("decay_e36_fig", figure_sel, 1);

    // Refill and refill/decay collision
    btn_reset = 1'b1; step(1); btn_reset = 1'b0;
    chk("sr1_levels", level_bus, lv(5,5,5,5));
    chk("sr1_state", pet_state, 0);
    step(12); chk("ref_e12", level_bus, lv(4,4,4,4));
    evt = 4'b0100; step(1); evt = 4'b0;
    chk("ref_sat", level_bus, lv(4,5,4,4));
    step(11); chk("ref_e24", level_bus, lv(3,4,3,3));
    step(11); evt = 4'b0010; step(1); evt = 4'b0;
    chk("collide_e36", level_bus, lv(2,3,5,2));
    chk("collide_state", pet_state, 1);
    chk("collide_fig", figure_sel, 1);
    step(11); chk("collide_e47", level_bus, lv(2,3,5,2));
    step(1);  chk("collide_e48", level_bus, lv(1,2,4,1));
    evt = 4'b1001; step(1); evt = 4'b0;
    chk("multi_evt", level_bus, lv(3,2,4,3));
    chk("multi_state", pet_state, 1);
    chk("lowest_needy_fig", figure_sel, 3);

    // Test mode
    btn_reset = 1'b1; step(1); btn_reset = 1'b0;
    btn_test = 1'b1; step(1); btn_test = 1'b0;
    chk("tm_on", test_active, 1);
    chk("tm_tick_e1", tick, 0);
    for (int e = 2; e <= 4; e++) begin
      step(1);
      chk("tick_test", tick, (e % 2 == 0) ? 1'b1 : 1'b0);
    end
    step(2); chk("tm_e6", level_bus, lv(5,5,5,5));
    step(1); chk("tm_e7", level_bus, lv(4,4,4,4));
    btn_test = 1'b1; step(1); btn_test = 1'b0;
    chk("tm_off", test_active, 0);
    for (int e = 9; e <= 12; e++) begin
      step(1);
      chk("tick_back", tick, (e == 11) ? 1'b1 : 1'b0);
    end

    // Death path: only channel 0 drains
    btn_reset = 1'b1; step(1); btn_reset = 1'b0;
    repeat (7) begin
      evt = 4'b1110; step(1); evt = 4'b0; step(7);
    end
    evt = 4'b1110; step(1); evt = 4'b0;
    step(2);
    chk("drain_e59", level_bus, lv(5,5,5,1));
    chk("drain_e59_state", pet_state, 1);
    step(1);
    chk("crit_levels", level_bus, lv(5,5,5,0));
    chk("crit_state", pet_state, 2);
    chk("crit_fig", figure_sel, 8);
    evt = 4'b1110; step(1); evt = 4'b0;
    step(6);
    chk("crit_e67", pet_state, 2);
    step(1);
    chk("dead_state", pet_state, 3);
    chk("dead_fig", figure_sel, 15);
    chk("dead_levels", level_bus, lv(5,5,5,0));
    evt = 4'b1111; step(1); evt = 4'b0;
    chk("dead_evt_ignored", level_bus, lv(5,5,5,0));
    step(10);
    chk("dead_tick_runs", tick, 1);
    chk("dead_frozen", level_bus, lv(5,5,5,0));
    chk("dead_sticky", pet_state, 3);

    // Soft reset overrides evt and btn_test
    btn_reset = 1'b1; evt = 4'b1111; btn_test = 1'b1;
    step(1);
    btn_reset = 1'b0; evt = 4'b0; btn_test = 1'b0;
    chk("sr2_levels", level_bus, lv(5,5,5,5));
    chk("sr2_state", pet_state, 0);
    chk("sr2_fig", figure_sel, 0);
    chk("sr2_test", test_active, 0);
    chk("sr2_tick", tick, 0);
    step(1); chk("sr2_tick_e1", tick, 0);
    step(2); chk("sr2_tick_e3", tick, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
